// File: rtl/err_stats_acc_pkg.sv
// Shared widths for the demod error-statistics path.
// Defaults used by err_stats_acc and err_stat_lane.
package err_stats_acc_pkg;
    localparam int ERR_W        = 18;  // error sample width, 1sFRAC
    localparam int ERR_FRAC     = 17;  // fractional bits of an error sample
    localparam int ERR_WIN_LOG2 = 4;   // nominal window length is 2**ERR_WIN_LOG2
endpackage

// File: rtl/err_stat_lane.sv
// One channel of the error statistics: square/truncate, power and DC accumulators,
// and the per-window result registers.
module err_stat_lane
    import err_stats_acc_pkg::*;
#(
    parameter int DATA_W   = ERR_W,
    parameter int FRAC_W   = ERR_FRAC,
    parameter int WIN_LOG2 = ERR_WIN_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              acc_en,
    input  logic              last,
    input  logic [DATA_W-1:0] err,
    output logic [DATA_W-2:0] ms_out,
    output logic [DATA_W-1:0] mean_out,
    output logic [DATA_W-2:0] ms_nxt,
    output logic              ovf_nxt
);
    localparam int SQ_W = DATA_W - 1;
    localparam int SA_W = SQ_W + WIN_LOG2;
    localparam int MA_W = DATA_W + WIN_LOG2;

    logic signed [2*DATA_W-1:0] err_x, prod;
    logic [SQ_W-1:0]            sq_d, sq_q;
    logic [DATA_W-1:0]          err_q;
    logic [SA_W-1:0]            sq_acc, sq_acc_nxt;
    logic [SA_W:0]              sq_sum;
    logic [MA_W-1:0]            mean_acc, mean_acc_nxt;
    logic [MA_W:0]              mean_sum;
    logic                       ovf_acc, sq_sat, mean_sat;
    logic                       unused_prod_bits;

    assign err_x = {{DATA_W{err[DATA_W-1]}}, err};
    assign prod  = err_x * err_x;
    // Only err = most-negative reaches bit 2*FRAC_W; clip it to just below 1.0.
    assign sq_d  = prod[2*FRAC_W] ? {SQ_W{1'b1}} : prod[2*FRAC_W-1 -: SQ_W];
    assign unused_prod_bits = ^{prod[2*DATA_W-1:2*FRAC_W+1], prod[FRAC_W-1:0]};

    assign sq_sum     = {1'b0, sq_acc} + {{(WIN_LOG2+1){1'b0}}, sq_q};
    assign sq_sat     = sq_sum[SA_W];
    assign sq_acc_nxt = sq_sat ? {SA_W{1'b1}} : sq_sum[SA_W-1:0];

    assign mean_sum = {mean_acc[MA_W-1], mean_acc} + {{(WIN_LOG2+1){err_q[DATA_W-1]}}, err_q};
    assign mean_sat = mean_sum[MA_W] ^ mean_sum[MA_W-1];
    always_comb begin
        mean_acc_nxt = mean_sum[MA_W-1:0];
        if (mean_sat)
            mean_acc_nxt = mean_sum[MA_W] ? {1'b1, {(MA_W-1){1'b0}}} : {1'b0, {(MA_W-1){1'b1}}};
    end

    // Saturated accumulators shifted by WIN_LOG2 always fit the output widths.
    assign ms_nxt  = sq_acc_nxt[SA_W-1:WIN_LOG2];
    assign ovf_nxt = ovf_acc | sq_sat | mean_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq_q     <= '0;
            err_q    <= '0;
            sq_acc   <= '0;
            mean_acc <= '0;
            ovf_acc  <= 1'b0;
            ms_out   <= '0;
            mean_out <= '0;
        end else begin
            if (load) begin
                sq_q  <= sq_d;
                err_q <= err;
            end
            if (flush) begin
                sq_acc   <= '0;
                mean_acc <= '0;
                ovf_acc  <= 1'b0;
            end else if (acc_en) begin
                if (last) begin
                    ms_out   <= ms_nxt;
                    mean_out <= mean_acc_nxt[MA_W-1:WIN_LOG2];
                    sq_acc   <= '0;
                    mean_acc <= '0;
                    ovf_acc  <= 1'b0;
                end else begin
                    sq_acc   <= sq_acc_nxt;
                    mean_acc <= mean_acc_nxt;
                    ovf_acc  <= ovf_nxt;
                end
            end
        end
    end
endmodule

// File: rtl/err_stats_acc.sv
// Multi-channel error power / DC accumulator: window control, sample counter,
// I+Q power sum and result strobe around NUM_CH err_stat_lane instances.
module err_stats_acc
    import err_stats_acc_pkg::*;
#(
    parameter int DATA_W   = ERR_W,
    parameter int FRAC_W   = ERR_FRAC,
    parameter int NUM_CH   = 2,
    parameter int WIN_LOG2 = ERR_WIN_LOG2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clk_en,
    input  logic                               clear,
    input  logic                               ext_mode,
    input  logic                               hold,
    input  logic [NUM_CH*DATA_W-1:0]           err_in,
    output logic [NUM_CH*(DATA_W-1)-1:0]       ms_out,
    output logic [NUM_CH*DATA_W-1:0]           mean_out,
    output logic [DATA_W-2+$clog2(NUM_CH):0]   pwr_out,
    output logic [WIN_LOG2:0]                  win_count_out,
    output logic                               ovf_out,
    output logic                               result_valid
);
    localparam int CNT_W = WIN_LOG2 + 1;
    localparam int PWR_W = DATA_W - 1 + $clog2(NUM_CH);

    logic                           mode_q, flush, s0_en, s2_en, last_d;
    logic                           s1_v, s1_last;
    logic [CNT_W-1:0]               cnt, cnt_inc, s1_cnt;
    logic [NUM_CH-1:0][DATA_W-2:0]  ms_nxt;
    logic [NUM_CH-1:0]              ovf_nxt;
    logic [PWR_W-1:0]               pwr_nxt;

    // A mode switch mid-window would mix two window definitions, so treat it as a clear.
    assign flush   = clear | (ext_mode != mode_q);
    assign s0_en   = clk_en & ~flush;
    assign s2_en   = s1_v & ~flush;
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign last_d  = ext_mode ? hold : (cnt == CNT_W'((1 << WIN_LOG2) - 1));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        err_stat_lane #(
            .DATA_W  (DATA_W),
            .FRAC_W  (FRAC_W),
            .WIN_LOG2(WIN_LOG2)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .load    (s0_en),
            .acc_en  (s2_en),
            .last    (s1_last),
            .err     (err_in[k*DATA_W +: DATA_W]),
            .ms_out  (ms_out[k*(DATA_W-1) +: DATA_W-1]),
            .mean_out(mean_out[k*DATA_W +: DATA_W]),
            .ms_nxt  (ms_nxt[k]),
            .ovf_nxt (ovf_nxt[k])
        );
    end

    always_comb begin
        pwr_nxt = '0;
        for (int k = 0; k < NUM_CH; k++)
            pwr_nxt = pwr_nxt + PWR_W'(ms_nxt[k]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q        <= 1'b0;
            cnt           <= '0;
            s1_v          <= 1'b0;
            s1_last       <= 1'b0;
            s1_cnt        <= '0;
            result_valid  <= 1'b0;
            pwr_out       <= '0;
            win_count_out <= '0;
            ovf_out       <= 1'b0;
        end else begin
            mode_q       <= ext_mode;
            result_valid <= 1'b0;
            if (flush) begin
                cnt  <= '0;
                s1_v <= 1'b0;
            end else begin
                s1_v <= clk_en;
                if (clk_en) begin
                    s1_last <= last_d;
                    s1_cnt  <= cnt_inc;
                    cnt     <= last_d ? '0 : cnt_inc;
                end
                if (s1_v && s1_last) begin
                    result_valid  <= 1'b1;
                    pwr_out       <= pwr_nxt;
                    win_count_out <= s1_cnt;
                    ovf_out       <= |ovf_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_err_stats_acc.sv
// Directed plus randomized checks of err_stats_acc against a window-level model.
module tb_err_stats_acc;
    localparam int DW  = 18;
    localparam int FW  = 17;
    localparam int NCH = 2;
    localparam int WL  = 4;
    localparam longint SQMAX = (64'sd1 <<< (DW - 1 + WL)) - 1;
    localparam longint MNMAX = (64'sd1 <<< (DW + WL - 1)) - 1;
    localparam longint MNMIN = -(64'sd1 <<< (DW + WL - 1));

    logic                       clk = 1'b0;
    logic                       reset, clk_en, clear, ext_mode, hold;
    logic [NCH*DW-1:0]          err_in;
    logic [NCH*(DW-1)-1:0]      ms_out;
    logic [NCH*DW-1:0]          mean_out;
    logic [DW-2+$clog2(NCH):0]  pwr_out;
    logic [WL:0]                win_count_out;
    logic                       ovf_out, result_valid;

    err_stats_acc #(.DATA_W(DW), .FRAC_W(FW), .NUM_CH(NCH), .WIN_LOG2(WL)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .clear(clear), .ext_mode(ext_mode),
        .hold(hold), .err_in(err_in), .ms_out(ms_out), .mean_out(mean_out),
        .pwr_out(pwr_out), .win_count_out(win_count_out), .ovf_out(ovf_out),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: open window, one pending result, and the held outputs.
    longint sqa[NCH], mna[NCH], o_ms[NCH], o_mn[NCH], p_ms[NCH], p_mn[NCH];
    longint o_pwr, p_pwr;
    int     wcnt, o_wc, p_wc;
    bit     wovf, o_ovf, p_ovf, pend, mode_prev, exp_rv;

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic longint dut_ms(int k);
        return longint'(ms_out[k*(DW-1) +: DW-1]);
    endfunction

    function automatic longint dut_mn(int k);
        return longint'($signed(mean_out[k*DW +: DW]));
    endfunction

    function automatic void win_clr();
        for (int k = 0; k < NCH; k++) begin sqa[k] = 0; mna[k] = 0; end
        wcnt = 0;
        wovf = 0;
    endfunction

    function automatic void model_reset();
        win_clr();
        for (int k = 0; k < NCH; k++) begin o_ms[k] = 0; o_mn[k] = 0; end
        o_pwr = 0; o_wc = 0; o_ovf = 0; pend = 0; mode_prev = 0; exp_rv = 0;
    endfunction

    task automatic check_outs(input string ph);
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("%s ms%0d", ph, k), dut_ms(k), o_ms[k]);
            chk($sformatf("%s mean%0d", ph, k), dut_mn(k), o_mn[k]);
        end
        chk({ph, " pwr"}, longint'(pwr_out), o_pwr);
        chk({ph, " wcnt"}, longint'(win_count_out), longint'(o_wc));
        chk({ph, " ovf"}, longint'(ovf_out), longint'(o_ovf));
        chk({ph, " valid"}, longint'(result_valid), longint'(exp_rv));
    endtask

    task automatic chk_res(input string t, input longint ms0, input longint ms1, input longint mn0,
                           input longint mn1, input longint pwr, input longint wc, input longint ovf);
        chk({t, " ms0"}, dut_ms(0), ms0);
        chk({t, " ms1"}, dut_ms(1), ms1);
        chk({t, " mean0"}, dut_mn(0), mn0);
        chk({t, " mean1"}, dut_mn(1), mn1);
        chk({t, " pwr"}, longint'(pwr_out), pwr);
        chk({t, " wcnt"}, longint'(win_count_out), wc);
        chk({t, " ovf"}, longint'(ovf_out), ovf);
    endtask

    // One clock: update the model from the spec rules, drive, then compare after the edge.
    task automatic step(input bit en, input int e0, input int e1, input bit hd, input bit clr);
        int     ev[NCH];
        bit     flush, last;
        int     cb;
        longint sq;
        ev[0] = e0; ev[1] = e1;
        flush  = clr || (ext_mode != mode_prev);
        exp_rv = 0;
        if (pend && !flush) begin
            for (int k = 0; k < NCH; k++) begin o_ms[k] = p_ms[k]; o_mn[k] = p_mn[k]; end
            o_pwr = p_pwr; o_wc = p_wc; o_ovf = p_ovf; exp_rv = 1;
        end
        pend = 0;
        if (flush) begin
            win_clr();
        end else if (en) begin
            cb   = wcnt;
            wcnt = (wcnt < (1 << (WL + 1)) - 1) ? wcnt + 1 : wcnt;
            for (int k = 0; k < NCH; k++) begin
                sq = (longint'(ev[k]) * longint'(ev[k])) >>> FW;
                if (sq > (64'sd1 <<< FW) - 1) sq = (64'sd1 <<< FW) - 1;
                sqa[k] += sq;
                if (sqa[k] > SQMAX) begin sqa[k] = SQMAX; wovf = 1; end
                mna[k] += ev[k];
                if (mna[k] > MNMAX) begin mna[k] = MNMAX; wovf = 1; end
                if (mna[k] < MNMIN) begin mna[k] = MNMIN; wovf = 1; end
            end
            last = ext_mode ? hd : (cb == (1 << WL) - 1);
            if (last) begin
                p_pwr = 0;
                for (int k = 0; k < NCH; k++) begin
                    p_ms[k] = sqa[k] >>> WL;
                    p_mn[k] = mna[k] >>> WL;
                    p_pwr  += p_ms[k];
                end
                p_wc = wcnt; p_ovf = wovf; pend = 1;
                win_clr();
            end
        end
        mode_prev = ext_mode;
        clk_en = en; hold = hd; clear = clr;
        err_in[0 +: DW]  = DW'(e0);
        err_in[DW +: DW] = DW'(e1);
        @(posedge clk);
        #1;
        check_outs("step");
    endtask

    task automatic run_win(input int n, input int e0, input int e1, input bit hold_last);
        for (int i = 0; i < n; i++)
            step(1'b1, e0, e1, hold_last && (i == n - 1), 1'b0);
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outs("areset");
        #2;
        reset  = 1'b0;
        clk_en = 1'b0; hold = 1'b0; clear = 1'b0;
    endtask

    function automatic int rand_err();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return -131072;
        if (r == 1) return 131071;
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    initial begin
        reset = 1'b1; clk_en = 1'b0; clear = 1'b0; ext_mode = 1'b0; hold = 1'b0; err_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("por");
        reset = 1'b0;

        // Nominal window of 0.5 on both lanes.
        run_win(16, 65536, 65536, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        chk_res("t1", 32768, 32768, 65536, 65536, 65536, 16, 0);

        // Most-negative input: square clipped, not flagged as overflow.
        run_win(16, -131072, -65536, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        chk_res("t2", 131071, 32768, -131072, -65536, 163839, 16, 0);

        // External window of 20 samples.
        ext_mode = 1'b1;
        step(1'b0, 0, 0, 1'b0, 1'b0);
        run_win(20, 65536, 65536, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        chk_res("t3", 40960, 40960, 81920, 81920, 81920, 20, 0);

        // External window of 17 full-scale negatives: both accumulators saturate.
        run_win(17, -131072, -131072, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        chk_res("t4", 131071, 131071, -131072, -131072, 262142, 17, 1);

        // Clear on the closing strobe suppresses the result.
        ext_mode = 1'b0;
        step(1'b0, 0, 0, 1'b0, 1'b0);
        run_win(15, 65536, 65536, 1'b0);
        step(1'b1, 65536, 65536, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        chk_res("t5 kept", 131071, 131071, -131072, -131072, 262142, 17, 1);
        run_win(16, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        chk_res("t5", 0, 0, 0, 0, 0, 16, 0);

        // Continuous strobes, alternating sign; reset lands while a result is in flight.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, (i % 2 == 1) ? -32768 : 32768, (i % 2 == 1) ? 32768 : -32768, 1'b0, 1'b0);
            if (i == 16) chk_res("t6", 8192, 8192, 0, 0, 16384, 16, 0);
        end
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
        chk("t6 stale", longint'(result_valid), 0);

        // Randomized traffic: gaps, random holds, clears and mode flips.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) ext_mode = ~ext_mode;
            step($urandom_range(0, 3) != 0, rand_err(), rand_err(),
                 $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
